// File: rtl/uart_tx_engine_if.sv
// tx FIFO read port: the engine (master) pops, the FIFO (slave) supplies
// the empty flag and registered read data.
interface uart_tx_engine_if #(
  parameter int FIFO_DW = 10
);
  logic               tx_fifo_re;
  logic               tx_fifo_empty;
  logic [FIFO_DW-1:0] tx_fifo_rdata;

  modport master (output tx_fifo_re, input tx_fifo_empty, input tx_fifo_rdata);
  modport slave  (input tx_fifo_re, output tx_fifo_empty, output tx_fifo_rdata);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops a word from the tx FIFO and serialises it as
// start / 5-9 data bits LSB first / optional parity / 1-2 stop bits.
module uart_tx_engine #(
  parameter int DIV_WIDTH = 16,
  parameter int FIFO_DW   = 10
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic                 r_tx_en,
  input  logic [DIV_WIDTH-1:0] r_baud_div,
  input  logic [3:0]           r_data_len,
  input  logic                 r_parity_en,
  input  logic                 r_parity_odd,
  input  logic                 r_stop2,
  uart_tx_engine_if.master     fifo,
  output logic                 uart_txd,
  output logic                 tx_busy,
  output logic                 int_status_tx_done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_e;

  typedef struct packed {
    logic [8:0]           data;
    logic                 brk;
    logic [DIV_WIDTH-1:0] div;
    logic [3:0]           len;
    logic                 par_en;
    logic                 par_odd;
    logic                 stop2;
  } frame_cfg_t;

  state_e               state_q, state_d;
  frame_cfg_t           cfg_q, cfg_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 txd_q, txd_d;
  logic                 bit_end, par_bit, done;

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
    end
  end

  assign bit_end = (baud_q == cfg_q.div - DIV_WIDTH'(1));

  // Parity covers only the len bits actually sent.
  always_comb begin
    par_bit = cfg_q.par_odd;
    for (int i = 0; i < 9; i++)
      if (i < int'(cfg_q.len)) par_bit = par_bit ^ cfg_q.data[i];
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (r_tx_en && !fifo.tx_fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        cfg_d.data    = fifo.tx_fifo_rdata[8:0];
        cfg_d.brk     = fifo.tx_fifo_rdata[FIFO_DW-1];
        cfg_d.div     = (r_baud_div == '0) ? DIV_WIDTH'(1) : r_baud_div;
        if (r_data_len < 4'd5)      cfg_d.len = 4'd5;
        else if (r_data_len > 4'd9) cfg_d.len = 4'd9;
        else                        cfg_d.len = r_data_len;
        cfg_d.par_en  = r_parity_en;
        cfg_d.par_odd = r_parity_odd;
        cfg_d.stop2   = r_stop2;
        baud_d  = '0;
        bit_d   = '0;
        stop_d  = 1'b0;
        state_d = START;
      end
      START: begin
        baud_d = baud_q + DIV_WIDTH'(1);
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + DIV_WIDTH'(1);
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == cfg_q.len - 4'd1) state_d = cfg_q.par_en ? PARITY : STOP;
          else                           bit_d   = bit_q + 4'd1;
        end
      end
      PARITY: begin
        baud_d = baud_q + DIV_WIDTH'(1);
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + DIV_WIDTH'(1);
        if (bit_end) begin
          baud_d = '0;
          if (stop_q == cfg_q.stop2) begin
            done    = 1'b1;
            stop_d  = 1'b0;
            state_d = (r_tx_en && !fifo.tx_fifo_empty) ? FETCH : IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is computed for the next state so the pad comes straight off a flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cfg_q.brk ? 1'b0 : cfg_q.data[bit_d];
      PARITY:  txd_d = cfg_q.brk ? 1'b0 : par_bit;
      default: txd_d = 1'b1;
    endcase
  end

  assign fifo.tx_fifo_re    = (state_q == FETCH);
  assign uart_txd           = txd_q;
  assign tx_busy            = (state_q != IDLE);
  assign int_status_tx_done = done;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART transmit protocol engine.
- Pops 10-bit words from the UART tx FIFO and serialises them on uart_txd: start bit, 5-9 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Sits between the tx FIFO read port (synchronous FIFO, registered read data) and the pad.
- Raises a per-frame done status that feeds the interrupt logic.

Parameters:
- DIV_WIDTH, 16, width of the baud divisor (clock cycles per bit).
- FIFO_DW, 10, tx FIFO word width. Word bits: [8:0] payload, [9] break request.

Ports:
- tx_clk  input  1  engine clock; same clock as the tx FIFO.
- tx_rst  input  1  synchronous, active-high reset.
- r_tx_en  input  1  transmit enable from regs.
- r_baud_div  input  DIV_WIDTH  cycles per bit; 0 is treated as 1.
- r_data_len  input  4  data bits per frame; valid 5..9, values <5 act as 5, values >9 act as 9.
- r_parity_en  input  1  parity bit enable.
- r_parity_odd  input  1  1 = odd parity, 0 = even parity.
- r_stop2  input  1  1 = two stop bits, 0 = one stop bit.
- tx_fifo_empty  input  1  FIFO empty flag.
- tx_fifo_rdata  input  FIFO_DW  FIFO read data; valid the cycle after tx_fifo_re.
- tx_fifo_re  output  1  FIFO pop, single-cycle pulse.
- uart_txd  output  1  serial line; idle high.
- tx_busy  output  1  high from FETCH through the end of the last stop bit.
- int_status_tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (synchronous, tx_rst=1 at a clock edge): next cycle uart_txd=1, tx_fifo_re=0, tx_busy=0, int_status_tx_done=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame. The line returns high at that edge. The popped word is lost; no done pulse is issued.
- States and transitions:
  - IDLE: go to FETCH when r_tx_en=1 and tx_fifo_empty=0.
  - FETCH: tx_fifo_re=1 for exactly this cycle. Always go to LOAD.
  - LOAD: capture tx_fifo_rdata, r_baud_div, r_data_len, r_parity_en, r_parity_odd, r_stop2 into shadow registers. These are held constant for the whole frame; register changes mid-frame take effect on the next frame. Go to START.
  - START: txd=0 for one bit period, then DATA.
  - DATA: txd = shadow data bit i, i=0..len-1, LSB first. Each bit lasts one bit period. After bit len-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: txd = XOR of the len data bits, inverted when odd parity. One bit period, then STOP.
  - STOP: txd=1 for 1 or 2 bit periods. At the final cycle, pulse int_status_tx_done=1 and go to FETCH if r_tx_en=1 and tx_fifo_empty=0, else IDLE.
- Bit period: baud counter counts 0..max(div,1)-1. A bit lasts exactly max(div,1) tx_clk cycles, and the counter reloads on each bit boundary.
- Break word (word[9]=1): START, DATA and PARITY all drive txd=0. The low time equals a normal frame's start+data+parity duration, followed by normal stop bits and a done pulse.
- Payload bits above len-1 are ignored and do not enter parity.
- Back-to-back frames: FETCH+LOAD insert exactly 2 tx_clk cycles of idle-high between the last stop bit and the next start bit.
- tx_busy=1 in FETCH, LOAD, START, DATA, PARITY and STOP; 0 in IDLE.
- r_tx_en deasserted mid-frame: the current frame completes normally, then the engine goes to IDLE. No new pop occurs.
- tx_fifo_re is never asserted while tx_fifo_empty=1 and never in two consecutive cycles.
- uart_txd is driven from a register, so the output is glitch-free.

Test Plan:
1. Reset, div=4, len=8, no parity, 1 stop, push 0x055 -> 1 pop; txd: 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; done pulses once; frame is 40 cycles after LOAD.
2. len=7, odd parity, stop2, word 0x0FF -> 7 ones; parity bit=0 (seven ones is odd, so the odd-parity bit is 0); stop high for 2 bit periods; payload bit 7 not sent.
3. Three words queued, div=1 -> three frames, each 10 cycles, separated by exactly 2 idle-high cycles; 3 pops, 3 done pulses; tx_busy stays 1 throughout.
4. Word 0x200 (break), len=8, parity on -> txd low for 10 bit periods, then stop high; done pulses.
5. r_baud_div changed and r_tx_en cleared mid-frame with a second word queued -> the frame finishes at the old divisor; no second pop; IDLE with txd=1.
6. tx_rst asserted during DATA -> txd=1 and tx_busy=0 on the next cycle; no done pulse; re-enable sends the next FIFO word cleanly; div=0 produces 1-cycle bits.
